// File: rtl/secuenciador_ascensor_pkg.sv
// rtl/secuenciador_ascensor_pkg.sv - shared encodings and dispatch rule for the elevator sequencer
package secuenciador_ascensor_pkg;

  localparam int NUM_PISOS = 10;

  localparam logic [2:0] REPOSO         = 3'd0;
  localparam logic [2:0] SUBIENDO       = 3'd1;
  localparam logic [2:0] BAJANDO        = 3'd2;
  localparam logic [2:0] PUERTA_ABIERTA = 3'd3;
  localparam logic [2:0] CERRANDO       = 3'd4;

  localparam logic [1:0] PARAR = 2'b00;
  localparam logic [1:0] SUBIR = 2'b01;
  localparam logic [1:0] BAJAR = 2'b10;

  // Returns {dir_arriba, next_state}; keeps going up while there is work above.
  function automatic logic [3:0] decidir(input logic aqui, input logic arriba,
                                         input logic abajo, input logic dir);
    if (aqui)               return {dir, PUERTA_ABIERTA};
    else if (dir && arriba) return {1'b1, SUBIENDO};
    else if (abajo)         return {1'b0, BAJANDO};
    else if (arriba)        return {1'b1, SUBIENDO};
    else                    return {dir, REPOSO};
  endfunction

endpackage

// File: rtl/secuenciador_ascensor_buscador_solicitudes.sv
// rtl/secuenciador_ascensor_buscador_solicitudes.sv - locates pending requests relative to a floor
module buscador_solicitudes #(
  parameter int N = 10
) (
  input  logic [N-1:0] i_solicitudes,
  input  logic [3:0]   i_piso,
  output logic         o_hay_aqui,
  output logic         o_hay_arriba,
  output logic         o_hay_abajo
);

  always_comb begin
    o_hay_aqui   = 1'b0;
    o_hay_arriba = 1'b0;
    o_hay_abajo  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_solicitudes[i]) begin
        if (i == int'(i_piso))     o_hay_aqui   = 1'b1;
        else if (i > int'(i_piso)) o_hay_arriba = 1'b1;
        else                       o_hay_abajo  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secuenciador_ascensor.sv
// rtl/secuenciador_ascensor.sv - elevator car sequencer: request latch, travel FSM and door timer
module secuenciador_ascensor #(
  parameter int TIEMPO_PUERTA = 50,
  parameter int NUM_PISOS     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PISOS-1:0] boton,
  input  logic                 sensor_piso,
  input  logic                 puerta_cerrada,
  output logic [1:0]           motor,
  output logic                 abrir_puerta,
  output logic [3:0]           piso_actual,
  output logic [NUM_PISOS-1:0] solicitudes,
  output logic                 ocupado
);
  import secuenciador_ascensor_pkg::*;

  localparam int CW = $clog2(TIEMPO_PUERTA + 1);

  logic [2:0]           r_estado, w_estado_sig;
  logic                 r_dir_arriba, w_dir_sig;
  logic [3:0]           r_piso, w_piso_sig;
  logic [NUM_PISOS-1:0] r_sol, w_sol_sig, w_clear;
  logic [CW-1:0]        r_cnt, w_cnt_sig;
  logic                 w_aqui, w_arriba, w_abajo;
  logic [3:0]           w_decision;

  // Floor the car will occupy after this edge; requests are searched from there.
  always_comb begin
    w_piso_sig = r_piso;
    if (sensor_piso) begin
      if (r_estado == SUBIENDO && r_piso != 4'(NUM_PISOS - 1))
        w_piso_sig = r_piso + 4'd1;
      else if (r_estado == BAJANDO && r_piso != 4'd0)
        w_piso_sig = r_piso - 4'd1;
    end
  end

  buscador_solicitudes #(.N(NUM_PISOS)) u_buscador (
    .i_solicitudes(r_sol),
    .i_piso       (w_piso_sig),
    .o_hay_aqui   (w_aqui),
    .o_hay_arriba (w_arriba),
    .o_hay_abajo  (w_abajo)
  );

  assign w_decision = decidir(w_aqui, w_arriba, w_abajo, r_dir_arriba);

  always_comb begin
    w_estado_sig = r_estado;
    w_dir_sig    = r_dir_arriba;
    case (r_estado)
      REPOSO: {w_dir_sig, w_estado_sig} = w_decision;
      SUBIENDO: begin
        if (sensor_piso) begin
          if (w_aqui)
            w_estado_sig = PUERTA_ABIERTA;
          else if (!w_arriba || w_piso_sig == 4'(NUM_PISOS - 1))
            {w_dir_sig, w_estado_sig} = w_decision;
        end
      end
      BAJANDO: begin
        if (sensor_piso) begin
          if (w_aqui)
            w_estado_sig = PUERTA_ABIERTA;
          else if (!w_abajo || w_piso_sig == 4'd0)
            {w_dir_sig, w_estado_sig} = w_decision;
        end
      end
      PUERTA_ABIERTA: if (r_cnt <= CW'(1)) w_estado_sig = CERRANDO;
      CERRANDO: begin
        if (boton[r_piso])
          w_estado_sig = PUERTA_ABIERTA;
        else if (puerta_cerrada)
          {w_dir_sig, w_estado_sig} = w_decision;
      end
      default: w_estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    w_cnt_sig = r_cnt;
    if (w_estado_sig == PUERTA_ABIERTA && r_estado != PUERTA_ABIERTA)
      w_cnt_sig = CW'(TIEMPO_PUERTA);
    else if (r_estado == PUERTA_ABIERTA && r_cnt != '0)
      w_cnt_sig = r_cnt - CW'(1);
  end

  // Serving a floor clears its bit even if the button is still held.
  assign w_clear   = (w_estado_sig == PUERTA_ABIERTA) ? (NUM_PISOS'(1) << w_piso_sig) : '0;
  assign w_sol_sig = (r_sol | boton) & ~w_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado     <= REPOSO;
      r_dir_arriba <= 1'b1;
      r_piso       <= 4'd0;
      r_sol        <= '0;
      r_cnt        <= '0;
    end else begin
      r_estado     <= w_estado_sig;
      r_dir_arriba <= w_dir_sig;
      r_piso       <= w_piso_sig;
      r_sol        <= w_sol_sig;
      r_cnt        <= w_cnt_sig;
    end
  end

  always_comb begin
    motor = PARAR;
    if (puerta_cerrada) begin
      if (r_estado == SUBIENDO)     motor = SUBIR;
      else if (r_estado == BAJANDO) motor = BAJAR;
    end
  end

  assign abrir_puerta = (r_estado == PUERTA_ABIERTA);
  assign ocupado      = (r_estado != REPOSO);
  assign piso_actual  = r_piso;
  assign solicitudes  = r_sol;

endmodule

// File: doc/secuenciador_ascensor.md
SECUENCIADOR_ASCENSOR -- requirements
Module: secuenciador_ascensor

Interface
REQ-001 Parameter TIEMPO_PUERTA, default 50: number of clock cycles the door is commanded open at a served floor.
REQ-002 Parameter NUM_PISOS, default 10: number of floors, numbered 0..NUM_PISOS-1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 boton  input  10  floor-call buttons; bit i high for one or more cycles registers a request for floor i.
REQ-006 sensor_piso  input  1  one-cycle pulse each time the car crosses a floor boundary.
REQ-007 puerta_cerrada  input  1  door-closed sensor; high means fully closed.
REQ-008 motor  output  2  motor command: 00 stop, 01 up, 10 down; 11 is never driven.
REQ-009 abrir_puerta  output  1  door open command.
REQ-010 piso_actual  output  4  current floor, 0..9.
REQ-011 solicitudes  output  10  pending request register.
REQ-012 ocupado  output  1  high in every state except REPOSO.

Function
REQ-013 The states SHALL be REPOSO, SUBIENDO, BAJANDO, PUERTA_ABIERTA and CERRANDO, plus a direction flag dir_arriba.
REQ-014 Each cycle solicitudes SHALL become (solicitudes | boton) & ~clear, where clear is the one-hot current-floor bit on a cycle that enters or remains in PUERTA_ABIERTA; clear wins over a simultaneous press of the same floor.
REQ-015 The decision rule, applied in REPOSO and on leaving CERRANDO, SHALL be:
- request at piso_actual -> PUERTA_ABIERTA;
- else dir_arriba=1 and any request above -> SUBIENDO;
- else any request below -> BAJANDO with dir_arriba=0;
- else any request above -> SUBIENDO with dir_arriba=1;
- else -> REPOSO.
REQ-016 motor SHALL be 01 in SUBIENDO, 10 in BAJANDO and 00 in every other state.
REQ-017 motor SHALL be forced to 00 in any cycle where puerta_cerrada is low.
REQ-018 A sensor_piso pulse in SUBIENDO SHALL increment piso_actual, and in BAJANDO SHALL decrement it, at the same clock edge.
REQ-019 piso_actual SHALL saturate at 0 and NUM_PISOS-1.
REQ-020 sensor_piso SHALL be ignored in all other states.
REQ-021 If a request exists at the floor just reached, the FSM SHALL enter PUERTA_ABIERTA on that same edge, so motor is 00 from the next cycle.
REQ-022 Otherwise, if no requests remain in the travel direction, the FSM SHALL apply REQ-015.
REQ-023 Reaching floor NUM_PISOS-1 while SUBIENDO, or floor 0 while BAJANDO, SHALL always leave that motion state.
REQ-024 PUERTA_ABIERTA SHALL assert abrir_puerta for exactly TIEMPO_PUERTA cycles, using a counter reloaded on entry, and then go to CERRANDO.
REQ-025 CERRANDO SHALL deassert abrir_puerta and wait for puerta_cerrada=1, then apply REQ-015.
REQ-026 In CERRANDO, a press of the current floor's button SHALL return the FSM to PUERTA_ABIERTA with the counter reloaded.
REQ-027 REPOSO with a request only at piso_actual SHALL open the door on the next edge without moving.

Reset
REQ-028 Asserting reset SHALL immediately set state=REPOSO, dir_arriba=1, piso_actual=0, solicitudes=0, motor=00, abrir_puerta=0, ocupado=0 and the door counter to 0.
REQ-029 Reset asserted during motion or while the door is open SHALL discard all pending requests.
REQ-030 After reset deasserts, operation SHALL begin on the first rising clock edge.

Structure
REQ-031 A shared package SHALL hold the state encoding, the motor codes (PARAR=00, SUBIR=01, BAJAR=10) and NUM_PISOS.
REQ-032 A combinational sub-module buscador_solicitudes SHALL take solicitudes and piso_actual and produce hay_aqui, hay_arriba and hay_abajo.

Verification
REQ-033 Reset, then boton[0] pulse at floor 0 -> PUERTA_ABIERTA next edge; abrir_puerta high for 50 cycles; solicitudes[0]=0.
REQ-034 At floor 0, boton[3] -> motor=01; after 3 sensor_piso pulses -> piso_actual=3, motor=00, door opens, solicitudes=0.
REQ-035 At floor 5 moving up with requests at 7 and 2 -> stops at 7, then motor=10, stops at 2.
REQ-036 In CERRANDO at floor 4, boton[4] pressed -> abrir_puerta re-asserted and the counter restarts at 50.
REQ-037 puerta_cerrada held low with a request pending -> motor stays 00 indefinitely.
REQ-038 Reset asserted mid-travel at floor 6 -> all outputs return to reset values asynchronously.
